synth_wrapper: RTL and testbench
================================

Name: synth_wrapper

Overview:
- Synthesizable top-level wrapper around a WIDTH-bit binary up/down counter with a single direction-select input.
- Counts up when sel=1 and down when sel=0, one step per clock.
- Wraps modulo 2^WIDTH in both directions.
- Used as the synthesis/gate-level top for the counter lab block; the output is fully registered.

Parameters:
- WIDTH, 4, counter width in bits; out width; wrap modulus 2^WIDTH.
- RST_VAL, 0, value loaded into the counter on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-high.
  - Despite the _n suffix, rst_n=1 resets the counter.
  - rst_n=0 runs the counter.
- sel  input  1  direction: 1 = count up, 0 = count down; sampled at each rising clk.
- out  output  WIDTH  current counter value, driven directly from the state register.

Behaviour:
- State: one WIDTH-bit register cnt; out = cnt, with no combinational path from sel to out.
- Reset, sampled at each rising clk:
  - rst_n=1: cnt <= RST_VAL (0 by default).
  - Reset has priority over sel.
  - While reset is held, out stays 0 on every edge.
  - Before the first edge with reset asserted, out is undefined; the bench asserts reset for at least one edge.
- Up: rst_n=0 and sel=1 -> cnt <= cnt + 1 mod 2^WIDTH.
  - 4'hF -> 4'h0 wrap, with no stall or saturation.
- Down: rst_n=0 and sel=0 -> cnt <= cnt - 1 mod 2^WIDTH.
  - 4'h0 -> 4'hF wrap.
- Latency: a sel change before edge N affects the value produced at edge N.
  - out reflects it immediately after edge N (1-cycle registered latency).
- Direction reversal: takes effect on the next edge with no dead cycle.
  - Example: 5 up -> 6, then sel=0 -> 5.
- Reset mid-count: on the first edge with rst_n=1, out returns to RST_VAL regardless of sel or current value.
  - Counting resumes from RST_VAL on the first edge after rst_n returns to 0.
- First step after reset release:
  - sel=1 gives 1.
  - sel=0 gives 4'hF (wrap from 0).
- No enable: the counter changes on every non-reset edge.
- Arithmetic: unsigned WIDTH-bit; carry/borrow is discarded, with no overflow flag.

Decomposition:
- Package counter_pkg:
  - Default WIDTH constant.
  - Direction enum dir_e (DIR_DOWN=1'b0, DIR_UP=1'b1).
  - Default reset value constant.
- Sub-module updown_counter_core:
  - Holds the parameterized register plus the increment/decrement/wrap logic.
  - Ports: clk, rst, dir, q.
- synth_wrapper instantiates one core, maps rst_n (active-high) to the core's reset and sel to dir, and drives out from q.

Test Plan:
- Reset hold:
  - Stimulus: rst_n=1 for 2+ edges, any sel.
  - Required: out=0 after the first edge and stays 0 while reset is held.
- Count up with max wrap:
  - Stimulus: release reset, sel=1 for 20 edges.
  - Required: out=1,2,...,15,0,1,...,4; the sample after 15 must be 0, never a skip to 0 without passing through 15.
- Count down with min wrap:
  - Stimulus: release reset, sel=0 for 20 edges.
  - Required: out=15,14,...,1,0,15,...,12; 0 must always precede 15.
- Direction reversal:
  - Stimulus: from reset, sel=1 for 5 edges (out=5), then sel=0 for 7 edges.
  - Required: out=4,3,2,1,0,15,14.
- Reset mid-operation:
  - Stimulus: count up to 9, assert rst_n=1 for 1 edge with sel=1, then release with sel=1.
  - Required: out=0 on the reset edge, then 1,2,...
- Random direction:
  - Stimulus: 100 edges with sel=$urandom%2.
  - Required: each sample equals previous ±1 mod 16 per sampled sel, checked against a scoreboard model.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter lab block.
// Direction encoding matches the raw sel pin: 1 = up, 0 = down.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 4;
  localparam int unsigned CNT_RST_DEF   = 0;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/updown_counter_core.sv
// Modulo-2^WIDTH up/down counter, one step per clock. Latency is 1 cycle and q is fully registered.
// There is no backpressure. The counter advances on every edge where rst is low.
module updown_counter_core
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH   = CNT_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(CNT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  dir_e             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;

  // Carry and borrow fall off the top bit, which gives the wrap in both directions.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (dir == DIR_UP) begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end else begin
      w_cnt_nxt = r_cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RST_VAL;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q = r_cnt;

endmodule

// File: rtl/synth_wrapper.sv
// Synthesis top for the counter lab block. out is the core register directly, with 1-cycle latency from sel.
// There is no backpressure. Note that rst_n is active-high despite its name.
module synth_wrapper
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH   = CNT_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(CNT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  dir_e             w_dir;
  logic [WIDTH-1:0] w_q;

  assign w_dir = dir_e'(sel);

  updown_counter_core #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_core (
    .clk (clk),
    .rst (rst_n),
    .dir (w_dir),
    .q   (w_q)
  );

  assign out = w_q;

endmodule

// File: tb/tb_synth_wrapper.sv
// Bench for synth_wrapper: directed vectors with literal expectations plus a modular-arithmetic model
// that is checked against out on every negedge once reset has been seen.
module tb_synth_wrapper;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic [W-1:0] out;

  int n_checks;
  int n_errs;
  int m_exp;
  bit m_vld;

  synth_wrapper #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: out is the running sum of +/-1 steps, taken mod 2^W, and it is cleared by reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_exp = 0;
      m_vld = 1'b1;
    end else if (m_vld) begin
      m_exp = (m_exp + (sel ? 1 : MOD - 1)) % MOD;
    end
  end

  always @(negedge clk) begin
    if (m_vld) begin
      n_checks++;
      if (out !== W'(m_exp)) begin
        n_errs++;
        $display("FAIL model t=%0t: out=%0d required=%0d", $time, out, m_exp);
      end
    end
  end

  task automatic apply(input logic r, input logic s, input int exp_lit, input string name);
    @(negedge clk);
    rst_n = r;
    sel   = s;
    @(posedge clk);
    #1;
    if (exp_lit >= 0) begin
      n_checks++;
      if (out !== W'(exp_lit)) begin
        n_errs++;
        $display("FAIL %s t=%0t: out=%0d required=%0d", name, $time, out, exp_lit);
      end
    end
  endtask

  int up_exp[20]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4};
  int dn_exp[20]  = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15, 14, 13, 12};
  int rev_exp[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 15, 14};
  int mid_exp[13] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errs   = 0;
    m_exp    = 0;
    m_vld    = 1'b0;
    rst_n    = 1'b1;
    sel      = 1'b0;

    // Reset is held across three edges with sel toggling, so out must stay 0.
    apply(1'b1, 1'b1, 0, "reset_hold");
    apply(1'b1, 1'b0, 0, "reset_hold");
    apply(1'b1, 1'b1, 0, "reset_hold");

    for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, up_exp[i], "count_up");

    apply(1'b1, 1'b1, 0, "reset_pre_down");
    apply(1'b1, 1'b0, 0, "reset_pre_down");
    for (int i = 0; i < 20; i++) apply(1'b0, 1'b0, dn_exp[i], "count_down");

    apply(1'b1, 1'b0, 0, "reset_pre_rev");
    for (int i = 0; i < 12; i++) apply(1'b0, (i < 5) ? 1'b1 : 1'b0, rev_exp[i], "reversal");

    apply(1'b1, 1'b0, 0, "reset_pre_mid");
    for (int i = 0; i < 13; i++) apply((i == 9) ? 1'b1 : 1'b0, 1'b1, mid_exp[i], "mid_reset");

    for (int i = 0; i < 100; i++) apply(1'b0, 1'($urandom % 2), -1, "random");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
